// File: rtl/tcam_ram_pkg.sv
// tcam_ram_pkg: shared helpers and FSM state type for the multi-read-port lookup RAM.
package tcam_ram_pkg;

    typedef enum logic {IDLE, CLEAR} state_t;

    // Address width for a given depth, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ram_sdp_nrd_rdch.sv
// ram_sdp_nrd_rdch: one read channel with range check, write bypass and a 1- or 2-stage data/valid pipeline.
module ram_sdp_nrd_rdch
    import tcam_ram_pkg::*;
#(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 16,
    parameter int OUT_REG   = 0,
    parameter int BYPASS    = 1,
    localparam int AW       = clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 idle,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH],
    output logic [RAM_WIDTH-1:0] rd_data,
    output logic                 rd_valid
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(RAM_DEPTH);

    logic                 en;
    logic                 hit;
    logic                 coll;
    logic                 v1;
    logic [RAM_WIDTH-1:0] word;
    logic [RAM_WIDTH-1:0] d1;

    // wr_en arrives already qualified by IDLE and the write range check.
    always_comb begin
        en   = idle && rd_en;
        hit  = {1'b0, rd_addr} < DEPTH_W;
        coll = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
        word = !hit ? '0 : coll ? wr_data : mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= en;
            if (en) d1 <= word;
        end

    if (OUT_REG != 0) begin : g_oreg
        logic                 v2;
        logic [RAM_WIDTH-1:0] d2;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        assign rd_valid = v2;
        assign rd_data  = d2;
    end else begin : g_nreg
        assign rd_valid = v1;
        assign rd_data  = d1;
    end

endmodule

// File: rtl/ram_sdp_nrd.sv
// ram_sdp_nrd: single-clock RAM with one write port, RD_PORTS read channels and a zero-sweep clear engine.
module ram_sdp_nrd
    import tcam_ram_pkg::*;
#(
    parameter int RAM_WIDTH  = 32,
    parameter int RAM_DEPTH  = 16,
    parameter int RD_PORTS   = 2,
    parameter int OUT_REG    = 0,
    parameter int BYPASS     = 1,
    parameter int INIT_CLEAR = 1,
    localparam int AW        = clog2(RAM_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [RAM_WIDTH-1:0]          wr_data,
    input  logic [RD_PORTS-1:0]           rd_en,
    input  logic [RD_PORTS*AW-1:0]        rd_addr,
    output logic [RD_PORTS*RAM_WIDTH-1:0] rd_data,
    output logic [RD_PORTS-1:0]           rd_valid,
    input  logic                          clr_req,
    output logic                          init_busy
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(RAM_DEPTH);
    localparam logic [AW:0] LAST_W  = (AW+1)'(RAM_DEPTH - 1);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    state_t               state;
    state_t               nxt;
    logic [AW-1:0]        clr_ptr;
    logic                 idle;
    logic                 last;
    logic                 wr_act;

    always_comb begin
        idle   = state == IDLE;
        last   = {1'b0, clr_ptr} == LAST_W;
        wr_act = idle && wr_en && ({1'b0, wr_addr} < DEPTH_W);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
        else        state <= nxt;

    // clr_req is only honoured from IDLE, so a running sweep never restarts.
    always_comb begin
        nxt = state;
        if (idle && clr_req)  nxt = CLEAR;
        else if (!idle && last) nxt = IDLE;
    end

    always_comb init_busy = state == CLEAR;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)     clr_ptr <= '0;
        else if (!idle) clr_ptr <= last ? '0 : clr_ptr + AW'(1);

    always_ff @(posedge clk)
        if (!idle)       mem[clr_ptr] <= '0;
        else if (wr_act) mem[wr_addr] <= wr_data;

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_ch
        ram_sdp_nrd_rdch #(
            .RAM_WIDTH (RAM_WIDTH),
            .RAM_DEPTH (RAM_DEPTH),
            .OUT_REG   (OUT_REG),
            .BYPASS    (BYPASS)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .idle     (idle),
            .rd_en    (rd_en[i]),
            .rd_addr  (rd_addr[i*AW +: AW]),
            .wr_en    (wr_act),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .mem      (mem),
            .rd_data  (rd_data[i*RAM_WIDTH +: RAM_WIDTH]),
            .rd_valid (rd_valid[i])
        );
    end

endmodule

// File: tb/tb_ram_sdp_nrd.sv
// tb_ram_sdp_nrd: two RAM configurations driven in lockstep, checked against a reference model and scoreboard.
module tb_ram_sdp_nrd;

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    logic         clk     = 0;
    logic         rst_n   = 1;
    logic         wr_en   = 0;
    logic [3:0]   wr_addr = 0;
    logic [31:0]  wr_data = 0;
    logic [3:0]   rd_en   = 0;
    logic [15:0]  rd_addr = 0;
    logic         clr_req = 0;
    logic [127:0] rdd  [2];
    logic [3:0]   rdv  [2];
    logic         busy [2];

    exp_t         q    [2][4][$];
    logic [31:0]  mdl  [2][16];
    logic [31:0]  last [2][4];
    int           cnt  [2] = '{12, 16};
    int           cyc      = 0;
    int           checks   = 0;
    int           failures = 0;

    // Instance 0: depth 12, latency 1, bypass on. Instance 1: depth 16, latency 2, bypass off.
    function automatic int dep(input int k); return k == 0 ? 12 : 16; endfunction
    function automatic int lat(input int k); return k == 0 ? 1 : 2;   endfunction
    function automatic int byp(input int k); return k == 0 ? 1 : 0;   endfunction

    ram_sdp_nrd #(.RAM_WIDTH(32), .RAM_DEPTH(12), .RD_PORTS(4), .OUT_REG(0), .BYPASS(1), .INIT_CLEAR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_valid(rdv[0]),
        .clr_req(clr_req), .init_busy(busy[0]));

    ram_sdp_nrd #(.RAM_WIDTH(32), .RAM_DEPTH(16), .RD_PORTS(4), .OUT_REG(1), .BYPASS(0), .INIT_CLEAR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_valid(rdv[1]),
        .clr_req(clr_req), .init_busy(busy[1]));

    always #5 clk = ~clk;

    // Reference model: sweep counter, memory image and expected read results.
    always @(posedge clk or negedge rst_n) begin
        int          a;
        logic [31:0] dv;
        exp_t        e;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                cnt[k] = dep(k);
                for (int c = 0; c < 4; c++) q[k][c].delete();
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (cnt[k] != 0) begin
                    mdl[k][dep(k) - cnt[k]] = 32'h0;
                    cnt[k]--;
                end else begin
                    for (int c = 0; c < 4; c++)
                        if (rd_en[c]) begin
                            a  = int'(rd_addr[c*4 +: 4]);
                            dv = (a >= dep(k)) ? 32'h0 :
                                 (byp(k) == 1 && wr_en && int'(wr_addr) == a) ? wr_data : mdl[k][a];
                            e.due = cyc + lat(k);
                            e.d   = dv;
                            q[k][c].push_back(e);
                        end
                    if (wr_en && int'(wr_addr) < dep(k)) mdl[k][wr_addr] = wr_data;
                    if (clr_req) cnt[k] = dep(k);
                end
            end
            cyc++;
        end
    end

    // Output monitor: busy flag, valid timing, data and hold behaviour.
    always @(negedge clk) begin
        logic [31:0] got;
        exp_t        e;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy[k] !== (cnt[k] != 0)) begin
                failures++;
                $display("FAIL busy inst%0d cyc=%0d got=%b want=%b", k, cyc, busy[k], cnt[k] != 0);
            end
            for (int c = 0; c < 4; c++) begin
                got = rdd[k][c*32 +: 32];
                if (!rst_n) last[k][c] = 32'h0;
                if (rdv[k][c] === 1'b1) begin
                    checks++;
                    if (q[k][c].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_valid inst%0d ch%0d cyc=%0d data=%h", k, c, cyc, got);
                    end else begin
                        e = q[k][c].pop_front();
                        if (e.due != cyc || got !== e.d) begin
                            failures++;
                            $display("FAIL read inst%0d ch%0d cyc=%0d got=%h want=%h due=%0d", k, c, cyc, got, e.d, e.due);
                        end
                        last[k][c] = e.d;
                    end
                end else begin
                    checks++;
                    if (rdv[k][c] !== 1'b0 || got !== last[k][c]) begin
                        failures++;
                        $display("FAIL hold inst%0d ch%0d cyc=%0d got=%h want=%h valid=%b", k, c, cyc, got, last[k][c], rdv[k][c]);
                    end
                    if (q[k][c].size() != 0 && q[k][c][0].due <= cyc) begin
                        checks++;
                        failures++;
                        $display("FAIL missing_valid inst%0d ch%0d cyc=%0d want=%h", k, c, cyc, q[k][c][0].d);
                        void'(q[k][c].pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en   = 0;
        rd_en   = 0;
        clr_req = 0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        wr_en   = 1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            rd_en = 4'hf;
            for (int c = 0; c < 4; c++) rd_addr[c*4 +: 4] = 4'((a + c) % 16);
            tick();
        end
        rd_en = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle_inputs();
        while (n < 10 && (q[0][0].size() + q[0][1].size() + q[0][2].size() + q[0][3].size() +
                          q[1][0].size() + q[1][1].size() + q[1][2].size() + q[1][3].size()) != 0) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (n >= 10) begin
            failures++;
            $display("FAIL drain_timeout pending results remain after %0d cycles", n);
        end
    endtask

    task automatic count_busy(input string name);
        int ca, cb;
        ca = 0;
        cb = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy[0]) ca++;
            if (busy[1]) cb++;
        end
        tick();
        checks++;
        if (ca != 12 || cb != 16) begin
            failures++;
            $display("FAIL %s sweep_len got=%0d/%0d want=12/16", name, ca, cb);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst_n = 0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rdv[k] !== 4'h0 || rdd[k] !== 128'h0 || busy[k] !== 1'b1) begin
                failures++;
                $display("FAIL reset_state inst%0d valid=%h data=%h busy=%b want 0/0/1", k, rdv[k], rdd[k], busy[k]);
            end
        end
        rst_n = 1;
        count_busy("reset");
        read_all();
        drain();
    endtask

    task automatic test_latency();
        do_write(4'd3, 32'hA5A5_0003);
        rd_en            = 4'b0010;
        rd_addr[7:4]     = 4'd3;
        tick();
        rd_en = 0;
        @(negedge clk);
        checks++;
        if (rdv[0][1] !== 1'b1 || rdv[1][1] !== 1'b0 || rdd[0][63:32] !== 32'hA5A5_0003) begin
            failures++;
            $display("FAIL latency_plus1 valid=%b/%b data=%h want 1/0 A5A50003", rdv[0][1], rdv[1][1], rdd[0][63:32]);
        end
        @(negedge clk);
        checks++;
        if (rdv[0][1] !== 1'b0 || rdv[1][1] !== 1'b1 || rdd[1][63:32] !== 32'hA5A5_0003) begin
            failures++;
            $display("FAIL latency_plus2 valid=%b/%b data=%h want 0/1 A5A50003", rdv[0][1], rdv[1][1], rdd[1][63:32]);
        end
        tick();
        drain();
    endtask

    task automatic test_collision();
        do_write(4'd5, 32'h11);
        wr_en        = 1;
        wr_addr      = 4'd5;
        wr_data      = 32'h22;
        rd_en        = 4'b0011;
        rd_addr[3:0] = 4'd5;
        rd_addr[7:4] = 4'd5;
        tick();
        idle_inputs();
        rd_en        = 4'b0001;
        tick();
        rd_en = 0;
        drain();
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 4; a++) do_write(4'(a), 32'hB0B0_0000 + a);
        rd_en   = 4'hf;
        rd_addr = {4'd3, 4'd2, 4'd1, 4'd0};
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) rd_en = 0;
            @(negedge clk);
            checks++;
            if (rdv[0] !== 4'hf || rdd[0] !== {32'hB0B0_0003, 32'hB0B0_0002, 32'hB0B0_0001, 32'hB0B0_0000}) begin
                failures++;
                $display("FAIL back_to_back beat%0d valid=%h data=%h", i, rdv[0], rdd[0]);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            rd_en   = 4'($urandom_range(0, 15));
            rd_addr = 16'($urandom);
            tick();
        end
        drain();
    endtask

    task automatic test_clear();
        int ca, cb;
        for (int a = 0; a < 16; a++) do_write(4'(a), 32'hC0DE_0000 + a);
        clr_req = 1;
        tick();
        clr_req = 0;
        ca = 0;
        cb = 0;
        for (int i = 0; i < 20; i++) begin
            wr_en   = (i < 10);
            wr_addr = 4'(i);
            wr_data = 32'hBAD0_0000 + i;
            rd_en   = (i < 10) ? 4'hf : 4'h0;
            rd_addr = 16'($urandom);
            clr_req = (i == 5);
            @(negedge clk);
            if (busy[0]) ca++;
            if (busy[1]) cb++;
            tick();
        end
        idle_inputs();
        checks++;
        if (ca != 12 || cb != 16) begin
            failures++;
            $display("FAIL clr_req sweep_len got=%0d/%0d want=12/16", ca, cb);
        end
        read_all();
        drain();
        for (int a = 0; a < 16; a++) do_write(4'(a), 32'h5EED_0000 + a);
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (6) tick();
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        count_busy("reset_mid_sweep");
        read_all();
        drain();
    endtask

    task automatic test_range();
        for (int a = 0; a < 12; a++) do_write(4'(a), 32'h7700_0000 + a);
        do_write(4'd14, 32'hDEAD_BEEF);
        rd_en         = 4'b0100;
        rd_addr[11:8] = 4'd13;
        tick();
        rd_en = 0;
        @(negedge clk);
        checks++;
        if (rdv[0][2] !== 1'b1 || rdd[0][95:64] !== 32'h0) begin
            failures++;
            $display("FAIL range_read valid=%b data=%h want 1 00000000", rdv[0][2], rdd[0][95:64]);
        end
        tick();
        read_all();
        drain();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 16; a++) mdl[k][a] = 32'h0;
            for (int c = 0; c < 4; c++) last[k][c] = 32'h0;
        end
        test_reset();
        test_latency();
        test_collision();
        test_back_to_back();
        test_random();
        test_clear();
        test_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
